// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped data cache: memory operations, controller states,
// default geometry, and a saturating increment used by the optional performance counters.
package dcache_pkg;

  localparam int DEFAULT_LINE_SIZE = 32;
  localparam int DEFAULT_XLEN      = 32;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    DC_IDLE      = 2'd0,
    DC_CHECK     = 2'd1,
    DC_WRITEBACK = 2'd2,
    DC_ALLOCATE  = 2'd3
  } dcache_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_word_counter.sv
// Word index within a cache line, shared by writeback and fill; wraps to 0 after the last word.
module dcache_word_counter #(
  parameter  int WORDS = 8,
  localparam int WIDTH = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == WIDTH'(WORDS - 1));

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Control FSM for the direct-mapped data cache: hit check, word-by-word writeback and line fill.
// Optional build macro DCACHE_PERF_COUNTERS_EN adds saturating hit/miss/writeback counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter  int LINE_SIZE      = DEFAULT_LINE_SIZE,
  parameter  int XLEN           = DEFAULT_XLEN,
  localparam int WORDS_PER_LINE = LINE_SIZE / (XLEN / 8),
  localparam int WORD_SEL_SIZE  = $clog2(WORDS_PER_LINE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  memory_operation_e        req_type,
  output logic                     req_fulfilled,
  input  logic                     hit,
  input  logic                     clean_miss,
  input  logic                     dirty_miss,
  output logic                     flush_mode,
  output logic                     load_mode,
  output logic                     clear_selected_dirty_bit,
  output logic                     finish_new_line_install,
  output logic [WORD_SEL_SIZE-1:0] counter,
  output logic                     l2_req_valid,
  output memory_operation_e        l2_req_op,
  input  logic                     l2_ack
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count,
  output logic [31:0]              writeback_count
`endif
);

  localparam logic [1:0] S_IDLE      = DC_IDLE;
  localparam logic [1:0] S_CHECK     = DC_CHECK;
  localparam logic [1:0] S_WRITEBACK = DC_WRITEBACK;
  localparam logic [1:0] S_ALLOCATE  = DC_ALLOCATE;

  logic [1:0] state, next_state;
  logic       last_word;
  logic       ack_last;
  logic       check_hit;
  logic       req_dropped;

  // req_type only feeds statistics outside this block.
  logic unused_req_type;
  assign unused_req_type = ^req_type;

  dcache_word_counter #(.WORDS(WORDS_PER_LINE)) u_word_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (l2_req_valid && l2_ack),
    .clear (state == S_IDLE),
    .count (counter),
    .last  (last_word)
  );

  assign ack_last  = l2_ack && last_word;
  assign check_hit = (state == S_CHECK) && req_valid && hit;

  always_comb begin
    // NOTE: defaulting next_state first keeps this block free of inferred latches.
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (!req_valid || hit) next_state = S_IDLE;
        else if (dirty_miss)   next_state = S_WRITEBACK;
        else if (clean_miss)   next_state = S_ALLOCATE;
      end
      S_WRITEBACK: begin
        if (ack_last) next_state = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        // An abandoned request still gets its line installed, but is never re-checked.
        if (ack_last) next_state = (req_dropped || !req_valid) ? S_IDLE : S_CHECK;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      req_fulfilled <= 1'b0;
      req_dropped   <= 1'b0;
    end else begin
      state         <= next_state;
      req_fulfilled <= check_hit;
      if (l2_req_valid && !req_valid) req_dropped <= 1'b1;
      else if (!l2_req_valid)         req_dropped <= 1'b0;
    end
  end

  assign flush_mode               = (state == S_WRITEBACK);
  assign l2_req_valid             = (state == S_WRITEBACK) || (state == S_ALLOCATE);
  assign l2_req_op                = (state == S_WRITEBACK) ? STORE : LOAD;
  assign load_mode                = (state == S_ALLOCATE) && l2_ack;
  assign clear_selected_dirty_bit = (state == S_WRITEBACK) && ack_last;
  assign finish_new_line_install  = (state == S_ALLOCATE) && ack_last;

`ifdef DCACHE_PERF_COUNTERS_EN
  logic recheck;
  logic check_miss;

  assign check_miss = (state == S_CHECK) && req_valid && !hit && (clean_miss || dirty_miss);

  always_ff @(posedge clk) begin
    if (reset) begin
      recheck         <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
      writeback_count <= '0;
    end else begin
      // The hit that completes a filled request belongs to the miss, not to the hit tally.
      if (state == S_ALLOCATE && next_state == S_CHECK) recheck <= 1'b1;
      else if (state == S_CHECK)                        recheck <= 1'b0;
      if (check_hit && !recheck) hit_count <= sat_inc(hit_count);
      if (check_miss)            miss_count <= sat_inc(miss_count);
      if (state == S_CHECK && next_state == S_WRITEBACK)
        writeback_count <= sat_inc(writeback_count);
    end
  end
`endif

endmodule
